// File: rtl/ram_uploader_if.sv
// ram_uploader_if: bundles the host-side upload handshake and the core-side
// ioctl read bus used by ram_uploader.
//   host_upload_*      : start/abort/size/type request from the host
//   host_updata*       : packed 32-bit word and its req/ack handshake
//   host_upload_busy   : transfer in progress
//   host_upload_sum    : byte checksum (zero when checksum logic is not built)
//   ioctl_*            : read side toward the core (upload, index, rd, addr, din, wait)
// Modports: master = the uploader, slave = the host/core side.
interface ram_uploader_if #(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 27
);
  logic              host_upload_start;
  logic              host_upload_abort;
  logic [LEN_W-1:0]  host_upload_size;
  logic [2:0]        host_file_type;
  logic [31:0]       host_updata;
  logic              host_updata_req;
  logic              host_updata_ack;
  logic              host_upload_busy;
  logic [15:0]       host_upload_sum;
  logic              ioctl_upload;
  logic [15:0]       ioctl_index;
  logic              ioctl_rd;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;

  modport master (
    input  host_upload_start, host_upload_abort, host_upload_size, host_file_type,
    input  host_updata_ack, ioctl_din, ioctl_wait,
    output host_updata, host_updata_req, host_upload_busy, host_upload_sum,
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr
  );

  modport slave (
    output host_upload_start, host_upload_abort, host_upload_size, host_file_type,
    output host_updata_ack, ioctl_din, ioctl_wait,
    input  host_updata, host_updata_req, host_upload_busy, host_upload_sum,
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr
  );
endinterface

// File: rtl/ram_uploader.sv
// ram_uploader: reads a byte range out of the core over the ioctl read side,
// packs the bytes big-endian into 32-bit words (first byte in [31:24]) and
// hands each word to the firmware over a level req / pulse ack handshake.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : ram_uploader_if.master (host request/handshake + ioctl read bus)
// Optional feature: define UPLOAD_CHECKSUM_EN to build the 16-bit wrap-around
// byte checksum on host_upload_sum; otherwise that output is tied to 0.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a start with non-zero size
// READ     | issue ioctl_rd for the next byte once ioctl_wait is low
// CAPTURE  | ioctl_din valid; store byte into its lane, advance addr/count
// PRESENT  | word offered to host (req high) until ack
// DONE     | one-cycle tail before dropping busy/upload
module ram_uploader #(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 27
) (
  input  logic           clk,
  input  logic           reset_n,
  ram_uploader_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, PRESENT, DONE} state_t;

  state_t            state;
  logic [LEN_W-1:0]  remain;      // bytes still to capture, counts down
  logic [1:0]        lane;
  logic [31:0]       word;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        file_type;
  logic              req;
  logic              busy;
`ifdef UPLOAD_CHECKSUM_EN
  logic [15:0]       sum;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      remain    <= '0;
      lane      <= '0;
      word      <= '0;
      addr      <= '0;
      file_type <= '0;
      req       <= 1'b0;
      busy      <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
      sum       <= '0;
`endif
    end else if (state != IDLE && bus.host_upload_abort) begin
      // addr, word and sum are left as they were for post-mortem inspection
      state <= IDLE;
      req   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.host_upload_start && bus.host_upload_size != '0) begin
            remain    <= bus.host_upload_size;
            file_type <= bus.host_file_type;
            addr      <= '0;
            lane      <= '0;
            word      <= '0;
            busy      <= 1'b1;
`ifdef UPLOAD_CHECKSUM_EN
            sum       <= '0;
`endif
            state     <= READ;
          end
        end
        READ: begin
          if (!bus.ioctl_wait) state <= CAPTURE;
        end
        CAPTURE: begin
          // lane 0 lands in [31:24]; {~lane,3'b000} is 8*(3-lane)
          word[{~lane, 3'b000} +: 8] <= bus.ioctl_din;
          addr   <= addr + 1'b1;
          remain <= remain - 1'b1;
          lane   <= lane + 1'b1;
`ifdef UPLOAD_CHECKSUM_EN
          sum    <= sum + {8'h00, bus.ioctl_din};
`endif
          if (lane == 2'd3 || remain == LEN_W'(1)) begin
            req   <= 1'b1;
            state <= PRESENT;
          end else begin
            state <= READ;
          end
        end
        PRESENT: begin
          if (bus.host_updata_ack) begin
            req   <= 1'b0;
            word  <= '0;
            lane  <= '0;
            state <= (remain == '0) ? DONE : READ;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The read strobe must react to ioctl_wait in the same cycle, so it is the
  // one output decoded from state rather than registered.
  assign bus.ioctl_rd         = (state == READ) && !bus.ioctl_wait;
  assign bus.ioctl_addr       = addr;
  assign bus.ioctl_index      = {13'b0, file_type};
  assign bus.ioctl_upload     = busy;
  assign bus.host_upload_busy = busy;
  assign bus.host_updata      = word;
  assign bus.host_updata_req  = req;
`ifdef UPLOAD_CHECKSUM_EN
  assign bus.host_upload_sum  = sum;
`else
  assign bus.host_upload_sum  = 16'h0000;
`endif

endmodule

// File: tb/tb_ram_uploader.sv
// tb_ram_uploader: directed bench for ram_uploader. The core model returns
// ioctl_din = addr[7:0] + 0x10 one cycle after each read strobe. Inputs are
// driven and outputs checked on the falling edge. Edge numbering in the
// comments follows the start pulse driven just after edge 0 and sampled at
// edge 1.
module tb_ram_uploader;
  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   rd_cnt = 0;
  logic [26:0] rd_log [64];
  int   base;
  bit   ok;

  always #5 clk = ~clk;

  ram_uploader_if #(.LEN_W(16), .ADDR_W(27)) bus ();

  ram_uploader #(.LEN_W(16), .ADDR_W(27)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // core read model and read-strobe monitor
  always @(posedge clk) begin
    if (bus.ioctl_rd) begin
      bus.ioctl_din <= bus.ioctl_addr[7:0] + 8'h10;
      rd_log[rd_cnt % 64] <= bus.ioctl_addr;
      rd_cnt <= rd_cnt + 1;
    end
  end

  function automatic logic [31:0] exp_sum(input logic [15:0] v);
`ifdef UPLOAD_CHECKSUM_EN
    return {16'h0, v};
`else
    return 32'h0 & {16'h0, v};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // returns at the falling edge after edge 1
  task automatic start_xfer(input logic [15:0] size, input logic [2:0] ftype);
    bus.host_upload_size  = size;
    bus.host_file_type    = ftype;
    bus.host_upload_start = 1'b1;
    step(1);
    bus.host_upload_start = 1'b0;
  endtask

  task automatic ack_pulse();
    bus.host_updata_ack = 1'b1;
    step(1);
    bus.host_updata_ack = 1'b0;
  endtask

  task automatic wait_req(output bit found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.host_updata_req === 1'b1) begin
        found = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic wait_idle(output bit found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.host_upload_busy === 1'b0) begin
        found = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  initial begin
    reset_n               = 1'b0;
    bus.host_upload_start = 1'b0;
    bus.host_upload_abort = 1'b0;
    bus.host_upload_size  = '0;
    bus.host_file_type    = '0;
    bus.host_updata_ack   = 1'b0;
    bus.ioctl_wait        = 1'b0;
    bus.ioctl_din         = 8'h00;
    step(2);

    // reset state
    chk("rst_busy",   32'(bus.host_upload_busy), 32'h0);
    chk("rst_req",    32'(bus.host_updata_req), 32'h0);
    chk("rst_upload", 32'(bus.ioctl_upload), 32'h0);
    chk("rst_rd",     32'(bus.ioctl_rd), 32'h0);
    chk("rst_data",   bus.host_updata, 32'h0);
    chk("rst_addr",   32'(bus.ioctl_addr), 32'h0);
    chk("rst_index",  32'(bus.ioctl_index), 32'h0);
    chk("rst_sum",    32'(bus.host_upload_sum), 32'h0);
    reset_n = 1'b1;
    step(1);

    // size 4: one word, req at edge 9, ack withheld 10 cycles
    base = rd_cnt;
    start_xfer(16'd4, 3'd5);
    chk("s4_busy_e1",   32'(bus.host_upload_busy), 32'h1);
    chk("s4_upload_e1", 32'(bus.ioctl_upload), 32'h1);
    chk("s4_rd_e1",     32'(bus.ioctl_rd), 32'h1);
    chk("s4_addr_e1",   32'(bus.ioctl_addr), 32'h0);
    chk("s4_index",     32'(bus.ioctl_index), 32'h5);
    step(7);
    chk("s4_req_e8", 32'(bus.host_updata_req), 32'h0);
    step(1);
    chk("s4_req_e9",  32'(bus.host_updata_req), 32'h1);
    chk("s4_word",    bus.host_updata, 32'h10111213);
    chk("s4_rd_cnt",  32'(rd_cnt - base), 32'd4);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold_req",  32'(bus.host_updata_req), 32'h1);
      chk("hold_word", bus.host_updata, 32'h10111213);
    end
    chk("hold_no_rd", 32'(rd_cnt - base), 32'd4);
    ack_pulse();
    chk("s4_req_drop",  32'(bus.host_updata_req), 32'h0);
    chk("s4_word_clr",  bus.host_updata, 32'h0);
    chk("s4_busy_done", 32'(bus.host_upload_busy), 32'h1);
    step(1);
    chk("s4_busy_low",   32'(bus.host_upload_busy), 32'h0);
    chk("s4_upload_low", 32'(bus.ioctl_upload), 32'h0);
    chk("s4_sum",        32'(bus.host_upload_sum), exp_sum(16'h004C));

    // size 5: two words, spurious ack while in READ
    base = rd_cnt;
    start_xfer(16'd5, 3'd1);
    ack_pulse();
    chk("s5_spur_req", 32'(bus.host_updata_req), 32'h0);
    wait_req(ok);
    chk("s5_w0_seen", 32'(ok), 32'h1);
    chk("s5_w0", bus.host_updata, 32'h10111213);
    ack_pulse();
    wait_req(ok);
    chk("s5_w1_seen", 32'(ok), 32'h1);
    chk("s5_w1", bus.host_updata, 32'h14000000);
    ack_pulse();
    wait_idle(ok);
    chk("s5_idle", 32'(ok), 32'h1);
    chk("s5_rd_cnt", 32'(rd_cnt - base), 32'd5);
    for (int i = 0; i < 5; i++) chk("s5_rd_addr", 32'(rd_log[(base + i) % 64]), 32'(i));
    chk("s5_addr_end", 32'(bus.ioctl_addr), 32'd5);
    chk("s5_sum", 32'(bus.host_upload_sum), exp_sum(16'h0060));

    // ioctl_wait: raised during CAPTURE of byte 1, stalls READ of byte 2 three cycles
    base = rd_cnt;
    start_xfer(16'd4, 3'd5);
    step(3);
    bus.ioctl_wait = 1'b1;
    step(1);
    chk("w_addr_e5", 32'(bus.ioctl_addr), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("w_rd_stall", 32'(bus.ioctl_rd), 32'h0);
      if (i < 3) step(1);
    end
    chk("w_rd_cnt_stall", 32'(rd_cnt - base), 32'd2);
    bus.ioctl_wait = 1'b0;
    #1;
    chk("w_rd_release", 32'(bus.ioctl_rd), 32'h1);
    step(3);
    chk("w_req_e11", 32'(bus.host_updata_req), 32'h0);
    step(1);
    chk("w_req_e12", 32'(bus.host_updata_req), 32'h1);
    chk("w_word",    bus.host_updata, 32'h10111213);
    ack_pulse();
    wait_idle(ok);
    chk("w_idle", 32'(ok), 32'h1);
    chk("w_rd_cnt", 32'(rd_cnt - base), 32'd4);

    // size-0 start ignored
    bus.host_upload_size  = 16'd0;
    bus.host_upload_start = 1'b1;
    step(1);
    bus.host_upload_start = 1'b0;
    chk("z_busy", 32'(bus.host_upload_busy), 32'h0);
    chk("z_rd",   32'(bus.ioctl_rd), 32'h0);

    // start while busy ignored, then abort at byte 2
    start_xfer(16'd8, 3'd5);
    step(1);
    bus.host_upload_size  = 16'd1;
    bus.host_file_type    = 3'd2;
    bus.host_upload_start = 1'b1;
    step(1);
    bus.host_upload_start = 1'b0;
    chk("sb_index", 32'(bus.ioctl_index), 32'h5);
    chk("sb_addr",  32'(bus.ioctl_addr), 32'd1);
    step(2);
    chk("ab_addr_pre", 32'(bus.ioctl_addr), 32'd2);
    chk("ab_rd_pre",   32'(bus.ioctl_rd), 32'h1);
    bus.host_upload_abort = 1'b1;
    step(1);
    bus.host_upload_abort = 1'b0;
    chk("ab_req",    32'(bus.host_updata_req), 32'h0);
    chk("ab_upload", 32'(bus.ioctl_upload), 32'h0);
    chk("ab_busy",   32'(bus.host_upload_busy), 32'h0);
    chk("ab_rd",     32'(bus.ioctl_rd), 32'h0);
    chk("ab_addr",   32'(bus.ioctl_addr), 32'd2);
    chk("ab_word",   bus.host_updata, 32'h10110000);
    chk("ab_sum",    32'(bus.host_upload_sum), exp_sum(16'h0021));
    start_xfer(16'd4, 3'd3);
    chk("rs_addr",  32'(bus.ioctl_addr), 32'd0);
    chk("rs_rd",    32'(bus.ioctl_rd), 32'h1);
    chk("rs_index", 32'(bus.ioctl_index), 32'h3);
    chk("rs_word",  bus.host_updata, 32'h0);

    // asynchronous reset while req is high
    wait_req(ok);
    chk("ar_req_seen", 32'(ok), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("ar_busy",   32'(bus.host_upload_busy), 32'h0);
    chk("ar_req",    32'(bus.host_updata_req), 32'h0);
    chk("ar_upload", 32'(bus.ioctl_upload), 32'h0);
    chk("ar_data",   bus.host_updata, 32'h0);
    chk("ar_addr",   32'(bus.ioctl_addr), 32'h0);
    chk("ar_index",  32'(bus.ioctl_index), 32'h0);
    chk("ar_sum",    32'(bus.host_upload_sum), 32'h0);
    step(1);
    reset_n = 1'b1;
    step(1);
    chk("ar_idle_busy", 32'(bus.host_upload_busy), 32'h0);
    chk("ar_idle_rd",   32'(bus.ioctl_rd), 32'h0);

    // size 1: single padded byte
    start_xfer(16'd1, 3'd0);
    wait_req(ok);
    chk("s1_seen", 32'(ok), 32'h1);
    chk("s1_word", bus.host_updata, 32'h10000000);
    ack_pulse();
    wait_idle(ok);
    chk("s1_idle", 32'(ok), 32'h1);
    chk("s1_addr", 32'(bus.ioctl_addr), 32'd1);
    chk("s1_sum",  32'(bus.host_upload_sum), exp_sum(16'h0010));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/ram_uploader.md
# ram_uploader

FPGA-to-host upload engine for the ZPUFlex control path: on a host request it reads a byte range out of the core over the ioctl read side (`ioctl_upload`/`ioctl_rd`/`ioctl_din`/`ioctl_wait`). It packs the bytes big-endian into 32-bit words and hands each word to the ZPUFlex firmware over a req/ack handshake. It is the reverse of the boot-data loader and sits beside it inside the hps_io substitute, driving the core's save/snapshot path.

## Interface
- `LEN_W`, 16: width of the transfer length in bytes.
- `ADDR_W`, 27: width of `ioctl_addr`.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `host_upload_start` in 1: one-cycle start pulse.
- `host_upload_abort` in 1: cancels the transfer in progress.
- `host_upload_size` in LEN_W: byte count, sampled on start.
- `host_file_type` in 3: file type, sampled on start.
- `host_updata` out 32: packed word; first byte sits in [31:24].
- `host_updata_req` out 1: word valid, level signal.
- `host_updata_ack` in 1: host consumed the word; one-cycle pulse.
- `host_upload_busy` out 1: transfer in progress.
- `host_upload_sum` out 16: byte checksum (see Configuration).
- `ioctl_upload` out 1: upload active toward the core.
- `ioctl_index` out 16: `{13'b0, file_type}`.
- `ioctl_rd` out 1: one-cycle read strobe.
- `ioctl_addr` out ADDR_W: byte address.
- `ioctl_din` in 8: read data, valid one cycle after `ioctl_rd`.
- `ioctl_wait` in 1: core stall; no new `ioctl_rd` is issued while it is high.

## Operation
- States: IDLE, READ, CAPTURE, PRESENT, DONE.
- **IDLE**
  - `host_upload_start` with size ≠ 0: latch size and type, clear addr, byte counter, lane counter, word and sum; go to READ.
  - Start with size = 0 is ignored.
  - Start while not in IDLE is ignored.
- **READ**
  - If `ioctl_wait` = 0: `ioctl_rd` = 1 for this cycle, go to CAPTURE.
  - Otherwise stay in READ with `ioctl_rd` = 0.
- **CAPTURE**
  - Write `ioctl_din` into lane (3 − lane), counting lane 0 as [31:24].
  - Add the byte to the sum, increment addr and byte counter.
  - If lane = 3 or this was the last byte: go to PRESENT. Otherwise go to READ.
- **PRESENT**
  - `host_updata_req` = 1; `host_updata` held stable.
  - On `host_updata_ack`: req drops, word clears to 0 and lane to 0. Go to DONE if all bytes are sent, else READ.
- **DONE**: one cycle, then IDLE. Clears `ioctl_upload` and `host_upload_busy`.
- `ioctl_upload` and `host_upload_busy` are high in every state except IDLE.
- A final partial word is zero-padded in its unused low bytes. Words transferred = ceil(size/4).
- `host_upload_abort` in any non-IDLE state goes to IDLE on the next edge:
  - drops req, upload, busy and rd;
  - leaves addr, sum and data at their current values.
- `host_updata_ack` is ignored outside PRESENT.
- Abort and ack in the same cycle: abort wins.
- `ioctl_addr` does not wrap within a transfer: its maximum is 2^LEN_W − 1.

## Timing
- Reset values: every output is 0; state is IDLE.
- Start sampled at edge 0:
  - edge 1: upload = busy = 1 and `ioctl_rd` = 1 at addr 0;
  - edge 2: capture;
  - each byte costs 2 cycles with no wait;
  - first `host_updata_req` rises at edge 9.
- Each cycle with `ioctl_wait` high in READ adds one cycle. A wait asserted during CAPTURE does not affect the byte already in flight.
- Ack sampled at edge n: req is low from edge n+1, and the next `ioctl_rd` is at edge n+1.
- For the last word, busy is low from edge n+2.
- `reset_n` low clears everything immediately (asynchronous), including mid-transfer.

## Configuration
- `UPLOAD_CHECKSUM_EN` defined:
  - `host_upload_sum` is the 16-bit wrap-around sum of all bytes captured.
  - Valid from the cycle busy falls until the next start, which clears it.
- Not defined: no sum logic is built and `host_upload_sum` is tied to 0.

## Test plan
- Size = 4, core returns `ioctl_din` = addr + 0x10 → one word 0x10111213, req at edge 9; ack → busy low 2 cycles later. Checksum 0x004C with the macro, 0x0000 without.
- Size = 5 → words 0x10111213 then 0x14000000; exactly 5 `ioctl_rd` pulses at addresses 0–4.
- `ioctl_wait` high for 3 cycles while READ is pending byte 2 → `ioctl_rd` for addr 2 delayed exactly 3 cycles; word unchanged 0x10111213.
- Ack withheld 10 cycles → req and `host_updata` stable throughout, no `ioctl_rd` issued; spurious ack while in READ ignored.
- Size = 0 start, and start while busy → no state change. `host_upload_abort` at byte 2 → next edge req, upload, busy all 0; a new start then begins at addr 0.
- `reset_n` pulsed low while req = 1 → all outputs 0 immediately, state IDLE after release.
